// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one bit per clock, LSB first,
// using a single full adder built from two half adders.
//
// state | meaning
// IDLE  | waiting for start; result/cout/overflow hold the last operation
// RUN   | one operand bit processed per clock, WIDTH clocks in total
// DONE  | one-cycle done pulse, outputs valid
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic ha1_s, ha1_c, ha2_c, sum_bit, carry_next, last_bit;

  // Two half adders plus an OR form the full adder.
  assign ha1_s      = op_a[0] ^ op_b[0];
  assign ha1_c      = op_a[0] & op_b[0];
  assign sum_bit    = ha1_s ^ carry;
  assign ha2_c      = ha1_s & carry;
  assign carry_next = ha1_c | ha2_c;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          carry  <= carry_next;
          result <= {sum_bit, result[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            cout     <= carry_next;
            overflow <= carry ^ carry_next;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
